// File: rtl/noc_output_port_scheduler.sv
// Wormhole output-port scheduler: round-robin per-packet arbitration, credit-based flow control,
// registered link outputs. Optional statistics counters are enabled by defining SCHED_STATS_EN.
module noc_output_port_scheduler #(
  parameter int NUM_INPUTS   = 5,
  parameter int FLIT_WIDTH   = 128,
  parameter int DEST_WIDTH   = 6,
  parameter int CREDIT_DEPTH = 2
) (
  input  logic                             clk_noc,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS-1:0]            req,
  input  logic [NUM_INPUTS-1:0]            req_tail,
  input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] req_data,
  input  logic [NUM_INPUTS*DEST_WIDTH-1:0] req_dest,
  output logic [NUM_INPUTS-1:0]            grant,
  output logic [FLIT_WIDTH-1:0]            data_out,
  output logic [DEST_WIDTH-1:0]            dest_out,
  output logic                             is_tail_out,
  output logic                             send_out,
  input  logic                             credit_in,
  output logic                             locked,
  output logic                             credit_err
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]                      stat_flits,
  output logic [31:0]                      stat_stalls
`endif
);

  localparam int CW = $clog2(CREDIT_DEPTH + 1);
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         lock_idx_q, lock_idx_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic [FLIT_WIDTH-1:0] data_q, data_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  tail_q, tail_d;
  logic                  send_q, send_d;
  logic                  cerr_q, cerr_d;

  logic                  can_send_s;
  logic                  gnt_valid_s;
  logic [IW-1:0]         gnt_idx_s;
  logic [FLIT_WIDTH-1:0] data_arr_s [NUM_INPUTS];
  logic [DEST_WIDTH-1:0] dest_arr_s [NUM_INPUTS];

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
    assign data_arr_s[gi] = req_data[gi*FLIT_WIDTH +: FLIT_WIDTH];
    assign dest_arr_s[gi] = req_dest[gi*DEST_WIDTH +: DEST_WIDTH];
  end

  assign can_send_s = (credits_q != {CW{1'b0}});

  // Arbitration: owner-only while locked, otherwise first requester at/after rr_ptr (mod N)
  always_comb begin
    logic [IW:0]   raw_s;
    logic [IW-1:0] cand_s;
    gnt_valid_s = 1'b0;
    gnt_idx_s   = {IW{1'b0}};
    raw_s       = {(IW+1){1'b0}};
    cand_s      = {IW{1'b0}};
    if (rst_n && can_send_s) begin
      if (state_q == ST_LOCKED) begin
        gnt_valid_s = req[lock_idx_q];
        gnt_idx_s   = lock_idx_q;
      end else begin
        // Scan offsets downward so the smallest offset is the last (winning) assignment
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
          raw_s  = {1'b0, rr_ptr_q} + (IW+1)'(k);
          cand_s = (raw_s >= (IW+1)'(NUM_INPUTS)) ? IW'(raw_s - (IW+1)'(NUM_INPUTS)) : IW'(raw_s);
          if (req[cand_s]) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = cand_s;
          end else begin
            gnt_valid_s = gnt_valid_s;
          end
        end
      end
    end else begin
      gnt_valid_s = 1'b0;
    end
  end

  assign grant = gnt_valid_s ? (NUM_INPUTS'(1'b1) << gnt_idx_s) : {NUM_INPUTS{1'b0}};

  // Next-state: packet lock, round-robin pointer, link registers and credit accounting
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    data_d     = data_q;
    dest_d     = dest_q;
    tail_d     = tail_q;
    send_d     = 1'b0;
    credits_d  = credits_q;
    cerr_d     = cerr_q;
    if (gnt_valid_s) begin
      send_d = 1'b1;
      data_d = data_arr_s[gnt_idx_s];
      dest_d = dest_arr_s[gnt_idx_s];
      tail_d = req_tail[gnt_idx_s];
      if (req_tail[gnt_idx_s]) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (gnt_idx_s == IW'(NUM_INPUTS - 1)) ? {IW{1'b0}} : gnt_idx_s + IW'(1);
      end else begin
        state_d    = ST_LOCKED;
        lock_idx_d = gnt_idx_s;
      end
    end else begin
      send_d = 1'b0;
    end
    case ({gnt_valid_s, credit_in})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CRED_FULL) begin
          cerr_d = 1'b1;
        end else begin
          credits_d = credits_q + CW'(1);
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  // State and link registers with synchronous active-low reset
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= {IW{1'b0}};
      rr_ptr_q   <= {IW{1'b0}};
      credits_q  <= CRED_FULL;
      data_q     <= {FLIT_WIDTH{1'b0}};
      dest_q     <= {DEST_WIDTH{1'b0}};
      tail_q     <= 1'b0;
      send_q     <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      credits_q  <= credits_d;
      data_q     <= data_d;
      dest_q     <= dest_d;
      tail_q     <= tail_d;
      send_q     <= send_d;
      cerr_q     <= cerr_d;
    end
  end

  assign data_out    = data_q;
  assign dest_out    = dest_q;
  assign is_tail_out = tail_q;
  assign send_out    = send_q;
  assign locked      = (state_q == ST_LOCKED);
  assign credit_err  = cerr_q;

`ifdef SCHED_STATS_EN
  logic [31:0] stat_flits_q, stat_flits_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  // Statistics next-state: granted flits and cycles blocked only by missing credit
  always_comb begin
    stat_flits_d  = stat_flits_q;
    stat_stalls_d = stat_stalls_q;
    if (gnt_valid_s) begin
      stat_flits_d = stat_flits_q + 32'd1;
    end else begin
      stat_flits_d = stat_flits_q;
    end
    if ((|req) && !can_send_s) begin
      stat_stalls_d = stat_stalls_q + 32'd1;
    end else begin
      stat_stalls_d = stat_stalls_q;
    end
  end

  // Statistics registers, wrapping naturally at 2^32
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      stat_flits_q  <= 32'd0;
      stat_stalls_q <= 32'd0;
    end else begin
      stat_flits_q  <= stat_flits_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_flits  = stat_flits_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_noc_output_port_scheduler.sv
// Self-checking bench for noc_output_port_scheduler: directed scenarios plus randomized traffic
// compared against a packet-level reference model.
module tb_noc_output_port_scheduler;

  localparam int N  = 5;
  localparam int FW = 128;
  localparam int DW = 6;
  localparam int CD = 2;

  logic            clk_noc;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_tail;
  logic [N*FW-1:0] req_data;
  logic [N*DW-1:0] req_dest;
  logic [N-1:0]    grant;
  logic [FW-1:0]   data_out;
  logic [DW-1:0]   dest_out;
  logic            is_tail_out;
  logic            send_out;
  logic            credit_in;
  logic            locked;
  logic            credit_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_credits = CD;
  bit            m_locked  = 1'b0;
  int            m_owner   = 0;
  int            m_rr      = 0;
  bit            m_err     = 1'b0;
  bit            m_send    = 1'b0;
  logic [FW-1:0] m_data    = '0;
  logic [DW-1:0] m_dest    = '0;
  bit            m_tail    = 1'b0;

  noc_output_port_scheduler #(
    .NUM_INPUTS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .CREDIT_DEPTH(CD)
  ) dut (
    .clk_noc(clk_noc), .rst_n(rst_n), .req(req), .req_tail(req_tail),
    .req_data(req_data), .req_dest(req_dest), .grant(grant),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .locked(locked),
    .credit_err(credit_err)
  );

  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  function automatic int model_grant();
    int idx;
    if (!rst_n || m_credits == 0) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Advance one clock and apply the packet-level rules to the model
  task automatic tick();
    int            g;
    bit            rs, cin, gtail;
    logic [FW-1:0] gd;
    logic [DW-1:0] gt;
    g   = model_grant();
    rs  = rst_n;
    cin = credit_in;
    gd = '0; gt = '0; gtail = 1'b0;
    if (g >= 0) begin
      gd    = req_data[g*FW +: FW];
      gt    = req_dest[g*DW +: DW];
      gtail = req_tail[g];
    end
    @(posedge clk_noc);
    if (!rs) begin
      m_credits = CD; m_locked = 1'b0; m_owner = 0; m_rr = 0; m_err = 1'b0;
      m_send = 1'b0; m_data = '0; m_dest = '0; m_tail = 1'b0;
    end else begin
      m_send = (g >= 0);
      if (g >= 0) begin
        m_data = gd; m_dest = gt; m_tail = gtail;
        if (gtail) begin
          m_locked = 1'b0;
          m_rr = (g + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner = g;
        end
      end
      if (g >= 0 && !cin) m_credits = m_credits - 1;
      else if (g < 0 && cin) begin
        if (m_credits == CD) m_err = 1'b1;
        else m_credits = m_credits + 1;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    req = '0; req_tail = '0; credit_in = 1'b0;
  endtask

  task automatic set_flit(input int i, input bit tail, input logic [FW-1:0] d, input logic [DW-1:0] t);
    req[i] = 1'b1; req_tail[i] = tail;
    req_data[i*FW +: FW] = d;
    req_dest[i*DW +: DW] = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '1; req_tail = '1; credit_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (grant !== 5'b00000) begin errors++; $display("FAIL reset_grant cyc%0d got=%b exp=00000", c, grant); end
      tick();
    end
    checks++;
    if (send_out !== 1'b0 || locked !== 1'b0 || credit_err !== 1'b0 || is_tail_out !== 1'b0 ||
        data_out !== 128'd0 || dest_out !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs got send=%b lock=%b err=%b tail=%b dest=%h exp all zero",
               send_out, locked, credit_err, is_tail_out, dest_out);
    end
    rst_n = 1'b1;
    set_idle();
  endtask

  task automatic test_credit_stall();
    logic [FW-1:0] d [3];
    for (int k = 0; k < 3; k++) d[k] = {$urandom, $urandom, $urandom, $urandom};
    set_idle();
    for (int k = 0; k < 2; k++) begin
      set_flit(2, 1'b0, d[k], 6'd9);
      #1;
      checks++;
      if (grant !== 5'b00100) begin errors++; $display("FAIL stall_grant%0d got=%b exp=00100", k, grant); end
      tick();
      checks++;
      if (send_out !== 1'b1 || data_out !== d[k] || is_tail_out !== 1'b0) begin
        errors++; $display("FAIL stall_send%0d got send=%b tail=%b exp send=1 tail=0 data match", k, send_out, is_tail_out);
      end
    end
    set_flit(2, 1'b1, d[2], 6'd9);
    #1;
    checks++;
    if (grant !== 5'b00000) begin errors++; $display("FAIL stall_nocredit got=%b exp=00000", grant); end
    tick();
    checks++;
    if (send_out !== 1'b0 || data_out !== d[1] || locked !== 1'b1) begin
      errors++; $display("FAIL stall_hold got send=%b lock=%b exp send=0 lock=1 data held", send_out, locked);
    end
    credit_in = 1'b1;
    #1;
    checks++;
    if (grant !== 5'b00000) begin errors++; $display("FAIL stall_credit_cycle got=%b exp=00000", grant); end
    tick();
    credit_in = 1'b0;
    #1;
    checks++;
    if (grant !== 5'b00100) begin errors++; $display("FAIL stall_resume got=%b exp=00100", grant); end
    tick();
    checks++;
    if (send_out !== 1'b1 || is_tail_out !== 1'b1 || data_out !== d[2] || locked !== 1'b0) begin
      errors++; $display("FAIL stall_tail got send=%b tail=%b lock=%b exp 1 1 0", send_out, is_tail_out, locked);
    end
    set_idle();
    credit_in = 1'b1;
    tick(); tick();
    credit_in = 1'b0;
    checks++;
    if (credit_err !== 1'b0) begin errors++; $display("FAIL stall_refill_err got=%b exp=0", credit_err); end
  endtask

  task automatic test_wormhole_lock();
    set_idle();
    credit_in = 1'b1;
    set_flit(1, 1'b0, 128'h11, 6'd1);
    #1;
    checks++;
    if (grant !== 5'b00010) begin errors++; $display("FAIL lock_head got=%b exp=00010", grant); end
    tick();
    set_flit(3, 1'b1, 128'h33, 6'd3);
    for (int c = 0; c < 2; c++) begin
      set_flit(1, 1'b0, 128'h12 + FW'(c), 6'd1);
      #1;
      checks++;
      if (grant !== 5'b00010) begin errors++; $display("FAIL lock_body%0d got=%b exp=00010", c, grant); end
      tick();
    end
    req[1] = 1'b0; credit_in = 1'b0;
    #1;
    checks++;
    if (grant !== 5'b00000) begin errors++; $display("FAIL lock_owner_stall got=%b exp=00000", grant); end
    tick();
    set_flit(1, 1'b1, 128'h1f, 6'd1);
    credit_in = 1'b1;
    #1;
    checks++;
    if (grant !== 5'b00010) begin errors++; $display("FAIL lock_tail got=%b exp=00010", grant); end
    tick();
    req[1] = 1'b0;
    #1;
    checks++;
    if (grant !== 5'b01000) begin errors++; $display("FAIL lock_next got=%b exp=01000", grant); end
    tick();
    checks++;
    if (send_out !== 1'b1 || dest_out !== 6'd3 || data_out !== 128'h33 || locked !== 1'b0 || credit_err !== 1'b0) begin
      errors++; $display("FAIL lock_next_out got send=%b dest=%0d lock=%b err=%b exp 1 3 0 0",
                         send_out, dest_out, locked, credit_err);
    end
    set_idle();
  endtask

  task automatic test_round_robin();
    int           e;
    logic [N-1:0] eg;
    rst_n = 1'b0; set_idle();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_flit(i, 1'b1, FW'(i) + 128'h100, DW'(i + 16));
    credit_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e  = k % N;
      eg = onehot(e);
      #1;
      checks++;
      if (grant !== eg) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, grant, eg); end
      tick();
      checks++;
      if (send_out !== 1'b1 || dest_out !== DW'(e + 16)) begin
        errors++; $display("FAIL rr_dest%0d got send=%b dest=%0d exp send=1 dest=%0d", k, send_out, dest_out, e + 16);
      end
    end
    set_idle();
  endtask

  task automatic test_credit_edges();
    logic [N-1:0] exp_g [4];
    bit           cin [4];
    exp_g[0] = 5'b00001; exp_g[1] = 5'b00001; exp_g[2] = 5'b00001; exp_g[3] = 5'b00000;
    cin[0] = 1'b0; cin[1] = 1'b1; cin[2] = 1'b0; cin[3] = 1'b0;
    set_idle();
    set_flit(0, 1'b1, 128'hc0, 6'd0);
    for (int c = 0; c < 4; c++) begin
      credit_in = cin[c];
      #1;
      checks++;
      if (grant !== exp_g[c]) begin errors++; $display("FAIL cred_seq%0d got=%b exp=%b", c, grant, exp_g[c]); end
      tick();
    end
    set_idle();
    credit_in = 1'b1;
    tick(); tick();
    credit_in = 1'b0;
    checks++;
    if (credit_err !== 1'b0) begin errors++; $display("FAIL cred_refill_err got=%b exp=0", credit_err); end
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    checks++;
    if (credit_err !== 1'b1) begin errors++; $display("FAIL cred_overflow_err got=%b exp=1", credit_err); end
    set_flit(0, 1'b1, 128'hc1, 6'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (grant !== ((c < 2) ? 5'b00001 : 5'b00000)) begin
        errors++; $display("FAIL cred_saturate%0d got=%b exp=%b", c, grant, (c < 2) ? 5'b00001 : 5'b00000);
      end
      tick();
    end
    checks++;
    if (credit_err !== 1'b1) begin errors++; $display("FAIL cred_err_sticky got=%b exp=1", credit_err); end
    set_idle();
    credit_in = 1'b1;
    tick(); tick();
    credit_in = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    set_idle();
    credit_in = 1'b1;
    set_flit(4, 1'b0, 128'h44, 6'd4);
    #1;
    checks++;
    if (grant !== 5'b10000) begin errors++; $display("FAIL midrst_head got=%b exp=10000", grant); end
    tick();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL midrst_locked got=%b exp=1", locked); end
    rst_n = 1'b0; credit_in = 1'b0;
    for (int i = 0; i < N; i++) set_flit(i, 1'b1, 128'h200 + FW'(i), DW'(i));
    #1;
    checks++;
    if (grant !== 5'b00000) begin errors++; $display("FAIL midrst_grant got=%b exp=00000", grant); end
    tick();
    checks++;
    if (locked !== 1'b0 || send_out !== 1'b0 || credit_err !== 1'b0) begin
      errors++; $display("FAIL midrst_state got lock=%b send=%b err=%b exp 0 0 0", locked, send_out, credit_err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (grant !== 5'b00001) begin errors++; $display("FAIL midrst_rr got=%b exp=00001", grant); end
    tick();
    checks++;
    if (send_out !== 1'b1 || is_tail_out !== 1'b1 || data_out !== 128'h200) begin
      errors++; $display("FAIL midrst_out got send=%b tail=%b exp 1 1", send_out, is_tail_out);
    end
    set_idle();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      req       = N'($urandom);
      req_tail  = N'($urandom);
      credit_in = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        req_data[i*FW +: FW] = {$urandom, $urandom, $urandom, $urandom};
        req_dest[i*DW +: DW] = DW'($urandom);
      end
      #1;
      eg = onehot(model_grant());
      checks++;
      if (grant !== eg) begin errors++; $display("FAIL rand_grant cyc%0d got=%b exp=%b", c, grant, eg); end
      tick();
      checks++;
      if (send_out !== m_send || is_tail_out !== m_tail || data_out !== m_data || dest_out !== m_dest ||
          locked !== m_locked || credit_err !== m_err) begin
        errors++;
        $display("FAIL rand_out cyc%0d got send=%b tail=%b dest=%0d lock=%b err=%b exp %b %b %0d %b %b",
                 c, send_out, is_tail_out, dest_out, locked, credit_err,
                 m_send, m_tail, m_dest, m_locked, m_err);
      end
    end
    rst_n = 1'b1;
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_tail = '0; req_data = '0; req_dest = '0; credit_in = 1'b0;
    @(negedge clk_noc);
    test_reset();
    test_credit_stall();
    test_wormhole_lock();
    test_round_robin();
    test_credit_edges();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
